// File: rtl/store_align_stage.sv
// Store alignment stage: turns one SB/SH/SW request into one or two
// word-aligned, byte-strobed write beats, then a one-cycle completion pulse.
module store_align_stage #(
  parameter int WORD_BYTES = 4,
  parameter int BYTE_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_funct3,
  input  logic [31:0]                  req_addr,
  input  logic [WORD_BYTES*BYTE_W-1:0] req_data,
  output logic                         mem_wvalid,
  input  logic                         mem_wready,
  output logic [31:0]                  mem_waddr,
  output logic [WORD_BYTES*BYTE_W-1:0] mem_wdata,
  output logic [WORD_BYTES-1:0]        mem_wstrb,
  output logic                         done,
  output logic                         err,
  output logic                         busy
);

  localparam int          DW        = WORD_BYTES * BYTE_W;
  localparam int          OFF_W     = $clog2(WORD_BYTES);
  localparam logic [31:0] LOW_MASK  = 32'(WORD_BYTES - 1);
  localparam logic [31:0] WORD_STEP = 32'(WORD_BYTES);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 base_q, base_d;
  logic [2*WORD_BYTES-1:0]     strb_q, strb_d;
  logic [2*DW-1:0]             data_q, data_d;
  logic                        illegal_q, illegal_d;

  logic                        wvalid_q, wvalid_d;
  logic [31:0]                 waddr_q, waddr_d;
  logic [DW-1:0]               wdata_q, wdata_d;
  logic [WORD_BYTES-1:0]       wstrb_q, wstrb_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        busy_q, busy_d;

  logic                        size_ok;
  int                          size_bytes;
  logic [WORD_BYTES-1:0]       size_strb;
  logic [DW-1:0]               size_mask;
  logic [OFF_W-1:0]            req_off;
  logic [31:0]                 shamt;
  logic [2*WORD_BYTES-1:0]     req_strb;
  logic [2*DW-1:0]             req_wdata;
  logic                        accept;
  logic                        split;

  assign req_ready = en && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign split     = |strb_q[2*WORD_BYTES-1:WORD_BYTES];

  // Decode width, then shift strobe and truncated data into a two-word window.
  always_comb begin
    size_ok    = 1'b1;
    size_bytes = 0;
    case (req_funct3)
      3'b000:  size_bytes = 1;
      3'b001:  size_bytes = 2;
      3'b010:  size_bytes = 4;
      default: size_ok = 1'b0;
    endcase
    size_strb = '0;
    size_mask = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (i < size_bytes) begin
        size_strb[i] = 1'b1;
        size_mask[i*BYTE_W +: BYTE_W] = '1;
      end
    end
    req_off   = req_addr[OFF_W-1:0];
    shamt     = 32'(req_off) * 32'(BYTE_W);
    req_strb  = {{WORD_BYTES{1'b0}}, size_strb} << req_off;
    req_wdata = {{DW{1'b0}}, req_data & size_mask} << shamt;
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    strb_d    = strb_q;
    data_d    = data_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          base_d    = req_addr & ~LOW_MASK;
          illegal_d = !size_ok;
          strb_d    = size_ok ? req_strb : '0;
          data_d    = size_ok ? req_wdata : '0;
          state_d   = size_ok ? BEAT0 : RESP;
        end
      end
      BEAT0: begin
        if (mem_wready) state_d = split ? BEAT1 : RESP;
      end
      BEAT1: begin
        if (mem_wready) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    wvalid_d = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;
    wstrb_d  = '0;
    case (state_d)
      BEAT0: begin
        wvalid_d = 1'b1;
        waddr_d  = base_d;
        wstrb_d  = strb_d[WORD_BYTES-1:0];
        wdata_d  = data_d[DW-1:0];
      end
      BEAT1: begin
        wvalid_d = 1'b1;
        waddr_d  = base_d + WORD_STEP;
        wstrb_d  = strb_d[2*WORD_BYTES-1:WORD_BYTES];
        wdata_d  = data_d[2*DW-1:DW];
      end
      default: ;
    endcase
    done_d = (state_d == RESP);
    err_d  = (state_d == RESP) && illegal_d;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      strb_q    <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
      wvalid_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      strb_q    <= strb_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
      wvalid_q  <= wvalid_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign mem_wvalid = wvalid_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_store_align_stage.sv
// Testbench for store_align_stage: table of store requests with a beat/response
// scoreboard, plus hand-written reset, enable and back-pressure sequences.
module tb_store_align_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  store_align_stage dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic err;
    int   cyc;
  } resp_t;

  typedef struct {
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    int          nbeats;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] d1;
    logic        err;
  } vec_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  beat_t mb;
  resp_t mr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;
  logic [3:0]  prev_strb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on accepted beats and done pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_wvalid && mem_wready) begin
        if (beat_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'(1), 64'(0));
        end else begin
          mb = beat_q.pop_front();
          checkOutput("beat_addr", 64'(mem_waddr), 64'(mb.addr));
          checkOutput("beat_strb", 64'(mem_wstrb), 64'(mb.strb));
          checkOutput("beat_data", 64'(mem_wdata), 64'(mb.data));
        end
      end
      if (!mem_wvalid) begin
        checkOutput("idle_bus_zero", {mem_waddr, mem_wdata}, 64'(0));
        checkOutput("idle_strb_zero", 64'(mem_wstrb), 64'(0));
      end
      if (prev_stall && mem_wvalid) begin
        checkOutput("stall_addr_data", {mem_waddr, mem_wdata}, {prev_addr, prev_data});
        checkOutput("stall_strb", 64'(mem_wstrb), 64'(prev_strb));
      end
      prev_stall = mem_wvalid && !mem_wready;
      prev_addr  = mem_waddr;
      prev_data  = mem_wdata;
      prev_strb  = mem_wstrb;
      if (!done) checkOutput("err_outside_done", 64'(err), 64'(0));
      if (done) begin
        if (resp_q.size() == 0) begin
          checkOutput("unexpected_done", 64'(1), 64'(0));
        end else begin
          mr = resp_q.pop_front();
          checkOutput("resp_err", 64'(err), 64'(mr.err));
          checkOutput("done_cycle", 64'(cyc), 64'(mr.cyc));
        end
      end
    end
  end

  task automatic waitReady();
    int guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit drop_en);
    int guard;
    int stall_left;
    waitReady();
    if (!req_ready) begin
      checkOutput("ready_timeout", 64'(req_ready), 64'(1));
      return;
    end
    if (v.nbeats > 0) beat_q.push_back('{v.a0, v.s0, v.d0});
    if (v.nbeats > 1) beat_q.push_back('{v.a1, v.s1, v.d1});
    resp_q.push_back('{v.err, cyc + 1 + v.nbeats + v.stall});
    req_valid  = 1'b1;
    req_funct3 = v.funct3;
    req_addr   = v.addr;
    req_data   = v.data;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_data   = $urandom;
    checkOutput("busy_active", 64'(busy), 64'(1));
    if (drop_en) en = 1'b0;
    stall_left = v.stall;
    guard = 0;
    while (resp_q.size() != 0 && guard < 60) begin
      if (mem_wvalid && stall_left > 0) begin
        mem_wready = 1'b0;
        stall_left--;
      end else begin
        mem_wready = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (resp_q.size() != 0) begin
      checkOutput("done_timeout", 64'(resp_q.size()), 64'(0));
      beat_q.delete();
      resp_q.delete();
    end
    mem_wready = 1'b1;
    checkOutput("ready_after_done", 64'(req_ready), 64'(en));
    if (drop_en) begin
      en = 1'b1;
      #1;
      checkOutput("ready_en_restored", 64'(req_ready), 64'(1));
    end
  endtask

  vec_t vecs[14];

  initial begin
    int guard;

    vecs[0]  = '{3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 32'h0, 4'h0, 32'h0, 1'b0};
    vecs[1]  = '{3'b000, 32'h0000_0203, 32'h1234_56AB, 0, 1, 32'h0000_0200, 4'h8, 32'hAB00_0000, 32'h0, 4'h0, 32'h0, 1'b0};
    vecs[2]  = '{3'b010, 32'h0000_0102, 32'hA1B2_C3D4, 0, 2, 32'h0000_0100, 4'hC, 32'hC3D4_0000, 32'h0000_0104, 4'h3, 32'h0000_A1B2, 1'b0};
    vecs[3]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 3, 2, 32'hFFFF_FFFC, 4'h8, 32'hEF00_0000, 32'h0000_0000, 4'h1, 32'h0000_00BE, 1'b0};
    vecs[4]  = '{3'b011, 32'h0000_0040, 32'h5555_AAAA, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
    vecs[5]  = '{3'b000, 32'h0000_0010, 32'hFFFF_FF5A, 0, 1, 32'h0000_0010, 4'h1, 32'h0000_005A, 32'h0, 4'h0, 32'h0, 1'b0};
    vecs[6]  = '{3'b001, 32'h0000_0022, 32'hFFFF_1234, 0, 1, 32'h0000_0020, 4'hC, 32'h1234_0000, 32'h0, 4'h0, 32'h0, 1'b0};
    vecs[7]  = '{3'b001, 32'h0000_0021, 32'h0000_5678, 1, 1, 32'h0000_0020, 4'h6, 32'h0056_7800, 32'h0, 4'h0, 32'h0, 1'b0};
    vecs[8]  = '{3'b010, 32'h0000_2003, 32'h1122_3344, 0, 2, 32'h0000_2000, 4'h8, 32'h4400_0000, 32'h0000_2004, 4'h7, 32'h0011_2233, 1'b0};
    vecs[9]  = '{3'b010, 32'h0000_2001, 32'hCAFE_F00D, 1, 2, 32'h0000_2000, 4'hE, 32'hFEF0_0D00, 32'h0000_2004, 4'h1, 32'h0000_00CA, 1'b0};
    vecs[10] = '{3'b111, 32'h0000_0003, 32'hFFFF_FFFF, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
    vecs[11] = '{3'b100, 32'h0000_0000, 32'h0000_0001, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
    vecs[12] = '{3'b001, 32'h0000_0007, 32'h0000_ABCD, 0, 2, 32'h0000_0004, 4'h8, 32'hCD00_0000, 32'h0000_0008, 4'h1, 32'h0000_00AB, 1'b0};
    vecs[13] = '{3'b000, 32'h0000_0001, 32'h0000_0077, 2, 1, 32'h0000_0000, 4'h2, 32'h0000_7700, 32'h0, 4'h0, 32'h0, 1'b0};

    rst        = 1'b0;
    en         = 1'b1;
    req_valid  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_data   = 32'h0;
    mem_wready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // Reset state
    checkOutput("rst_wvalid", 64'(mem_wvalid), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_err", 64'(err), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_ready_en1", 64'(req_ready), 64'(1));
    en = 1'b0;
    #1;
    checkOutput("rst_ready_en0", 64'(req_ready), 64'(0));

    // Requests must not be accepted while en is low
    req_valid  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0300;
    req_data   = 32'h0BAD_0BAD;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("en_low_no_accept_busy", 64'(busy), 64'(0));
    end
    req_valid = 1'b0;
    en = 1'b1;
    #1;

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], 1'b0);

    // en dropped mid-transaction must not abort it
    applyStimulus(vecs[2], 1'b1);
    applyStimulus(vecs[3], 1'b1);

    // Reset while beat1 is stalled drops the transaction
    waitReady();
    beat_q.push_back('{32'h0000_0100, 4'hC, 32'hC3D4_0000});
    req_valid  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0102;
    req_data   = 32'hA1B2_C3D4;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    mem_wready = 1'b1;
    guard = 0;
    while (!(mem_wvalid && mem_waddr == 32'h0000_0104) && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("beat1_reached", 64'(mem_wvalid && mem_waddr == 32'h0000_0104), 64'(1));
    mem_wready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checkOutput("midrst_wvalid", 64'(mem_wvalid), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_done", 64'(done), 64'(0));
    beat_q.delete();
    resp_q.delete();
    mem_wready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_done", 64'(done), 64'(0));
    end
    checkOutput("midrst_ready", 64'(req_ready), 64'(en));

    // Stage still works after the mid-transaction reset
    applyStimulus(vecs[0], 1'b0);

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_empty", 64'(beat_q.size() + resp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
